// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS generator and its frequency meter.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    GATE,
    REPORT
  } meter_state_t;

  localparam int unsigned DDS_PA_WIDTH   = 23;
  localparam int unsigned DDS_TUNE_WIDTH = 16;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Result handshake of the frequency meter: tuning-word estimate with valid/ready.
interface dds_freq_meter_if
  import dds_pkg::*;
#(
  parameter int unsigned TUNE_WIDTH = DDS_TUNE_WIDTH
);

  logic [TUNE_WIDTH-1:0] tw_est;
  logic                  ovf;
  logic                  meas_valid;
  logic                  meas_ready;

  modport master (
    output tw_est,
    output ovf,
    output meas_valid,
    input  meas_ready
  );

  modport slave (
    input  tw_est,
    input  ovf,
    input  meas_valid,
    output meas_ready
  );

endinterface

// File: rtl/hyst_edge_det.sv
// Registers the sample stream and flags hysteresis-qualified rising crossings
// as a single-cycle pulse.
module hyst_edge_det #(
  parameter int unsigned           BITWIDTH = 32,
  parameter logic [BITWIDTH-1:0]   HI_THR   = {2'b11, {(BITWIDTH-2){1'b0}}},
  parameter logic [BITWIDTH-1:0]   LO_THR   = {2'b01, {(BITWIDTH-2){1'b0}}}
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [BITWIDTH-1:0] sig_in,
  output logic                rise
);

  logic [BITWIDTH-1:0] s_q;
  logic                low_seen;

  // The crossing is visible in the same cycle s_q first reaches HI_THR.
  assign rise = low_seen && (s_q >= HI_THR);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s_q      <= '0;
      low_seen <= 1'b0;
    end else begin
      s_q <= sig_in;
      if (s_q < LO_THR) begin
        low_seen <= 1'b1;
      end else if (rise) begin
        low_seen <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dds_freq_meter.sv
// Counts crossings of a DDS sample stream over a 2^GATE_LOG2-clock gate and
// reports the result in phase-accumulator tuning-word units.
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int unsigned         BITWIDTH   = 32,
  parameter int unsigned         TUNE_WIDTH = DDS_TUNE_WIDTH,
  parameter int unsigned         PA_WIDTH   = DDS_PA_WIDTH,
  parameter int unsigned         GATE_LOG2  = 16,
  parameter logic [BITWIDTH-1:0] HI_THR     = {2'b11, {(BITWIDTH-2){1'b0}}},
  parameter logic [BITWIDTH-1:0] LO_THR     = {2'b01, {(BITWIDTH-2){1'b0}}}
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                en,
  input  logic [BITWIDTH-1:0] sig_in,
  dds_freq_meter_if.master    res
);

  localparam int unsigned CNT_W = GATE_LOG2 + 1;
  localparam int unsigned EST_W = TUNE_WIDTH + 1 + PA_WIDTH;
  localparam int unsigned SHIFT = PA_WIDTH - GATE_LOG2;
  localparam logic [EST_W-1:0] TW_MAX = {{(EST_W-TUNE_WIDTH){1'b0}}, {TUNE_WIDTH{1'b1}}};

  meter_state_t           state;
  logic [GATE_LOG2-1:0]   timer;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [EST_W-1:0]       est;
  logic [TUNE_WIDTH-1:0]  res_tw;
  logic                   res_ovf;
  logic                   rise;

  logic [TUNE_WIDTH-1:0]  tw_q;
  logic                   ovf_q;
  logic                   valid_q;

  hyst_edge_det #(
    .BITWIDTH (BITWIDTH),
    .HI_THR   (HI_THR),
    .LO_THR   (LO_THR)
  ) u_edge (
    .clk    (clk),
    .RST    (RST),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // Result is formed from the count including an edge in the final gate cycle.
  always_comb begin
    cnt_next = edge_cnt;
    if (rise && (edge_cnt != '1)) begin
      cnt_next = edge_cnt + CNT_W'(1);
    end
    est     = EST_W'(cnt_next) << SHIFT;
    res_ovf = (est > TW_MAX) || (cnt_next == '1);
    res_tw  = res_ovf ? '1 : est[TUNE_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      edge_cnt <= '0;
      tw_q     <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer    <= '0;
          edge_cnt <= '0;
          if (en) begin
            state <= ARM;
          end
        end

        ARM: begin
          if (!en) begin
            state <= IDLE;
            timer <= '0;
          end else if (rise) begin
            state    <= GATE;
            timer    <= '0;
            edge_cnt <= '0;
          end else if (timer == '1) begin
            state   <= REPORT;
            tw_q    <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            timer <= timer + GATE_LOG2'(1);
          end
        end

        GATE: begin
          if (!en) begin
            state    <= IDLE;
            timer    <= '0;
            edge_cnt <= '0;
          end else begin
            edge_cnt <= cnt_next;
            if (timer == '1) begin
              state   <= REPORT;
              tw_q    <= res_tw;
              ovf_q   <= res_ovf;
              valid_q <= 1'b1;
            end else begin
              timer <= timer + GATE_LOG2'(1);
            end
          end
        end

        REPORT: begin
          // en is sampled only at acceptance so a pending result is never dropped.
          if (res.meas_ready) begin
            valid_q  <= 1'b0;
            timer    <= '0;
            edge_cnt <= '0;
            state    <= en ? ARM : IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign res.tw_est     = tw_q;
  assign res.ovf        = ovf_q;
  assign res.meas_valid = valid_q;

endmodule

// File: doc/dds_freq_meter.md
# dds_freq_meter

Measures the output frequency of a DDS sample stream and reports it as an estimated tuning word, closing the loop on the DDS generator for self-test and calibration. It counts hysteresis-qualified rising crossings over a fixed gate of 2^GATE_LOG2 clocks. It scales the count into the same tuning-word units the phase accumulator consumes (f = tw·f_clk/2^PA_WIDTH). Results leave through a valid/ready handshake.

## Interface
- BITWIDTH, 32, width of the sample input (matches DDS sig_out)
- TUNE_WIDTH, 16, width of reported tuning-word estimate
- PA_WIDTH, 23, phase-accumulator width used for scaling; requires GATE_LOG2 ≤ PA_WIDTH
- GATE_LOG2, 16, gate length is 2^GATE_LOG2 clocks
- HI_THR, 3·2^(BITWIDTH-2), upper crossing threshold (unsigned)
- LO_THR, 2^(BITWIDTH-2), lower re-arm threshold; requires LO_THR < HI_THR
- clk  input  1  sole clock, rising edge
- RST  input  1  asynchronous, active-high reset
- en  input  1  high: measure continuously; low: return to/stay in IDLE
- sig_in  input  BITWIDTH  unsigned DDS sample stream
- tw_est  output  TUNE_WIDTH  estimated tuning word; reset 0
- ovf  output  1  estimate saturated; qualified by meas_valid; reset 0
- meas_valid  output  1  result available; reset 0
- meas_ready  input  1  consumer accepts result

## Operation
- sig_in is registered once (s_q); all comparisons use s_q.
- Hysteresis: a `low_seen` flag sets when s_q < LO_THR. A rising crossing (`edge`) is a cycle where low_seen=1 and s_q ≥ HI_THR. That cycle clears low_seen. low_seen resets to 0.
- States:
  - IDLE: counters cleared. If en=1, go to ARM.
  - ARM: the timer counts cycles. The first edge goes to GATE; that edge is not counted and the timer is cleared. If the timer reaches 2^GATE_LOG2 with no edge, load tw_est=0, ovf=0 and go to REPORT (timeout).
  - GATE: the timer counts k=1..2^GATE_LOG2. Each edge at k in [1, 2^GATE_LOG2], inclusive, increments edge_cnt. At k=2^GATE_LOG2, load the result and go to REPORT.
  - REPORT: meas_valid=1; tw_est and ovf are held stable. Edges are ignored. On meas_valid & meas_ready, go to ARM if en=1, else IDLE. The next cycle has meas_valid=0.
- Scaling: est = edge_cnt << (PA_WIDTH − GATE_LOG2), computed at TUNE_WIDTH+1+PA_WIDTH bits. If est > 2^TUNE_WIDTH−1, then tw_est = all ones and ovf=1. Otherwise tw_est = est and ovf=0.
- edge_cnt saturates at its maximum and never wraps; saturation forces ovf.
- en=0 in ARM or GATE aborts to IDLE next cycle and produces no result. en=0 in REPORT does not drop meas_valid; the pending result must still be accepted.
- RST asserted in any state forces IDLE, clears low_seen, counters and all outputs immediately (asynchronous). Deassertion is synchronised by the system reset bridge.

## Timing
- sig_in → s_q: 1 cycle. The edge is recognised in the cycle s_q crosses.
- Final gate cycle (k=2^GATE_LOG2) → meas_valid high on the next rising edge.
- Measurement period ≈ first-edge wait + 2^GATE_LOG2 + 1 + handshake wait.
- meas_valid, tw_est and ovf are registered outputs; there is no combinational path from meas_ready.
- Back-to-back measurements: after acceptance, ARM waits for a fresh edge. Edges during REPORT are lost by design.

## Structure
- Package dds_pkg: typedef enum {IDLE, ARM, GATE, REPORT} meter_state_t; shared localparams for the PA_WIDTH/TUNE_WIDTH defaults used by dds and the meter.
- One sub-module, `hyst_edge_det`: registers the input and applies the LO_THR/HI_THR hysteresis, outputting a 1-cycle edge pulse. The FSM, timer, counter and scaler stay in dds_freq_meter.

## Test plan
- Square wave 0 / 2^32−1, period 256 clocks, en=1, meas_ready=1 → tw_est=0x8000 (256 edges <<7), ovf=0; repeats each measurement.
- Square wave period 1000 → 65 edges → tw_est=8320, ovf=0.
- Square wave period 128 → 512 edges → tw_est=0xFFFF, ovf=1.
- Constant sig_in=0 → timeout after 65536 ARM cycles → meas_valid=1, tw_est=0, ovf=0. Glitches oscillating between 0x9000_0000 and 0xB000_0000 (never < LO_THR after first crossing) → at most one edge, no extra counts.
- Hold meas_ready=0 for 100 cycles after meas_valid → tw_est/ovf stable, meas_valid held. Deassert en during REPORT → result still delivered, then IDLE.
- Assert RST mid-GATE (k=30000) → all outputs 0 in the same cycle. After release with en=1, the next result is correct (0x8000 for period 256). Drop en mid-GATE → no meas_valid, state IDLE.
